shift_seq_ctrl: RTL and testbench

- Sequencer for the serial-in/parallel-out shift register (`shift_reg`: `clk`, `n_rst`, 1-bit `in`, WIDTH-bit `out`).
- Accepts a parallel word over a valid/ready request handshake and drives it MSB-first into the register's serial input, one bit per clock.
- After WIDTH shifts, captures the register's parallel output and compares it against the request.
- Returns the captured word and a match flag over a valid/ready response handshake; sits between a host/test sequencer and `shift_reg`.

---
 rtl/shift_seq_ctrl.sv | 99 +++++++++
 tb/tb_shift_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Sequencer that serialises a request word MSB-first into shift_reg, then
// captures the register's parallel output and returns it with a match flag.
module shift_seq_ctrl #(
  parameter int   WIDTH    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             abort,
  output logic             sr_in,
  input  logic [WIDTH-1:0] sr_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_match,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b0;
    sr_in     = IDLE_BIT;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy  = 1'b1;
        sr_in = data_q[cnt];
        if (abort)         state_nxt = IDLE;
        else if (cnt == '0) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
        if (abort) state_nxt = IDLE;
        else       state_nxt = RESP;
      end
      RESP: begin
        busy = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The counter exits SHIFT at zero, so it never has to wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q    <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_match <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            data_q <= req_data;
            cnt    <= CNT_W'(WIDTH - 1);
          end
        end
        SHIFT: begin
          if (!abort && cnt != '0) cnt <= cnt - 1'b1;
        end
        CAPTURE: begin
          if (!abort) begin
            rsp_data  <= sr_out;
            rsp_match <= (sr_out == data_q);
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl: behavioural shift_reg plus a word-level
// reference model for serial order, latency and response contents.
module tb_shift_seq_ctrl;

  localparam int   WIDTH    = 4;
  localparam logic IDLE_BIT = 1'b0;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic             abort;
  logic             sr_in;
  logic [WIDTH-1:0] sr_out;
  logic [WIDTH-1:0] sr_q;
  logic             force_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_match;
  logic             busy;

  int checks = 0;
  int passed = 0;

  shift_seq_ctrl #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .abort     (abort),
    .sr_in     (sr_in),
    .sr_out    (sr_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_match (rsp_match),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for shift_reg; force_zero lets a test corrupt the captured word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sr_q <= '0;
    else        sr_q <= {sr_q[WIDTH-2:0], sr_in};
  end
  assign sr_out = force_zero ? '0 : sr_q;

  // Expected serial stream: element i is the bit on sr_in in the i-th shift cycle.
  function automatic logic [WIDTH-1:0] model_serial(input logic [WIDTH-1:0] word);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) v[i] = ((int'(word) >> (WIDTH - 1 - i)) % 2) == 1;
    return v;
  endfunction

  // Drives one request and records what the DUT did; comparisons stay in the callers.
  task automatic do_txn(input logic [WIDTH-1:0] word, input int stall, input bit force_mm,
                        input bit abort_resp, output logic [WIDTH-1:0] bits,
                        output logic [WIDTH-1:0] cap, output int lat,
                        output logic [WIDTH-1:0] data, output logic match, output bit stable,
                        output logic valid_after, output logic ready_after);
    req_data  = word;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    abort     = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      bits[i] = sr_in;
      @(posedge clk); #1;
    end
    lat        = WIDTH;
    cap        = sr_q;
    force_zero = force_mm;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    force_zero = 1'b0;
    data   = rsp_data;
    match  = rsp_match;
    stable = 1'b1;
    abort  = abort_resp;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== data || rsp_match !== match) stable = 1'b0;
    end
    abort     = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready   = 1'b0;
    valid_after = rsp_valid;
    ready_after = req_ready;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; req_valid = 1'b0; req_data = '0; abort = 1'b0;
    rsp_ready = 1'b0; force_zero = 1'b0;
    #3;
    checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid got %b expected 0", rsp_valid); else passed++;
    checks++; if (rsp_data !== '0) $display("[TB] FAIL reset_rsp_data got %h expected 0", rsp_data); else passed++;
    checks++; if (rsp_match !== 1'b0) $display("[TB] FAIL reset_rsp_match got %b expected 0", rsp_match); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b expected 0", busy); else passed++;
    checks++; if (sr_in !== IDLE_BIT) $display("[TB] FAIL reset_sr_in got %b expected %b", sr_in, IDLE_BIT); else passed++;
    #9 n_rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready got %b expected 1", req_ready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] bits, cap, data;
    logic match, va, ra;
    int lat;
    bit stable;
    do_txn(4'h8, 0, 1'b0, 1'b0, bits, cap, lat, data, match, stable, va, ra);
    checks++; if (bits !== model_serial(4'h8)) $display("[TB] FAIL basic_serial got %b expected %b", bits, model_serial(4'h8)); else passed++;
    checks++; if (cap !== 4'h8) $display("[TB] FAIL basic_shiftreg got %h expected 8", cap); else passed++;
    checks++; if (lat !== WIDTH + 1) $display("[TB] FAIL basic_latency got %0d expected %0d", lat, WIDTH + 1); else passed++;
    checks++; if (data !== 4'h8) $display("[TB] FAIL basic_rsp_data got %h expected 8", data); else passed++;
    checks++; if (match !== 1'b1) $display("[TB] FAIL basic_rsp_match got %b expected 1", match); else passed++;
    checks++; if (va !== 1'b0) $display("[TB] FAIL basic_valid_drop got %b expected 0", va); else passed++;
    checks++; if (ra !== 1'b1) $display("[TB] FAIL basic_ready_back got %b expected 1", ra); else passed++;
  endtask

  task automatic test_back_to_back();
    int accepts[$];
    logic [WIDTH-1:0] rd[$];
    logic rm[$];
    int viol;
    viol = 0;
    req_data  = 4'hA;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int e = 0; e < 30 && !(accepts.size() == 2 && rd.size() == 2); e++) begin
      if (req_ready === busy) viol++;
      if (rsp_valid === 1'b1) begin
        rd.push_back(rsp_data);
        rm.push_back(rsp_match);
      end
      if (req_ready === 1'b1 && req_valid) accepts.push_back(e);
      @(posedge clk); #1;
      if (accepts.size() == 1) req_data = 4'h5;
      if (accepts.size() == 2) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++; if (accepts.size() != 2) $display("[TB] FAIL b2b_accepts got %0d expected 2", accepts.size()); else passed++;
    checks++; if (rd.size() != 2) $display("[TB] FAIL b2b_responses got %0d expected 2", rd.size()); else passed++;
    if (accepts.size() == 2) begin
      checks++; if (accepts[1] - accepts[0] !== WIDTH + 3) $display("[TB] FAIL b2b_spacing got %0d expected %0d", accepts[1] - accepts[0], WIDTH + 3); else passed++;
    end
    if (rd.size() == 2) begin
      checks++; if (rd[0] !== 4'hA || rm[0] !== 1'b1) $display("[TB] FAIL b2b_first got %h/%b expected a/1", rd[0], rm[0]); else passed++;
      checks++; if (rd[1] !== 4'h5 || rm[1] !== 1'b1) $display("[TB] FAIL b2b_second got %h/%b expected 5/1", rd[1], rm[1]); else passed++;
    end
    checks++; if (viol != 0) $display("[TB] FAIL b2b_ready_vs_busy got %0d violations expected 0", viol); else passed++;
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] bits, cap, data;
    logic match, va, ra;
    int lat;
    bit stable;
    // abort is held during the stall as well; RESP must ignore it.
    do_txn(4'hC, 7, 1'b0, 1'b1, bits, cap, lat, data, match, stable, va, ra);
    checks++; if (stable !== 1'b1) $display("[TB] FAIL bp_stable got %b expected 1", stable); else passed++;
    checks++; if (data !== 4'hC || match !== 1'b1) $display("[TB] FAIL bp_rsp got %h/%b expected c/1", data, match); else passed++;
    checks++; if (va !== 1'b0) $display("[TB] FAIL bp_single_handshake got %b expected 0", va); else passed++;
  endtask

  task automatic test_mismatch();
    logic [WIDTH-1:0] bits, cap, data;
    logic match, va, ra;
    int lat;
    bit stable;
    do_txn(4'h9, 0, 1'b1, 1'b0, bits, cap, lat, data, match, stable, va, ra);
    checks++; if (data !== 4'h0) $display("[TB] FAIL mm_rsp_data got %h expected 0", data); else passed++;
    checks++; if (match !== 1'b0) $display("[TB] FAIL mm_rsp_match got %b expected 0", match); else passed++;
  endtask

  task automatic test_abort();
    logic [WIDTH-1:0] bits, cap, data, prev;
    logic match, va, ra;
    int lat;
    bit stable, saw;
    prev      = rsp_data;
    req_data  = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) $display("[TB] FAIL abort_idle got busy=%b ready=%b expected 0/1", busy, req_ready); else passed++;
    checks++; if (sr_in !== IDLE_BIT) $display("[TB] FAIL abort_sr_in got %b expected %b", sr_in, IDLE_BIT); else passed++;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid !== 1'b0) saw = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (saw !== 1'b0) $display("[TB] FAIL abort_no_rsp got %b expected 0", saw); else passed++;
    checks++; if (rsp_data !== prev) $display("[TB] FAIL abort_rsp_held got %h expected %h", rsp_data, prev); else passed++;
    // abort together with req_valid in IDLE must still accept the request.
    abort = 1'b1;
    do_txn(4'h3, 0, 1'b0, 1'b0, bits, cap, lat, data, match, stable, va, ra);
    checks++; if (data !== 4'h3 || match !== 1'b1 || lat !== WIDTH + 1) $display("[TB] FAIL abort_followup got %h/%b lat %0d expected 3/1 lat %0d", data, match, lat, WIDTH + 1); else passed++;
  endtask

  task automatic test_async_reset();
    logic [WIDTH-1:0] bits, cap, data;
    logic match, va, ra;
    int lat;
    bit stable;
    req_data  = 4'($urandom_range(1, 15));
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    n_rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) $display("[TB] FAIL arst_state got busy=%b ready=%b expected 0/1", busy, req_ready); else passed++;
    checks++; if (rsp_data !== '0 || rsp_match !== 1'b0 || rsp_valid !== 1'b0) $display("[TB] FAIL arst_rsp got %h/%b/%b expected 0/0/0", rsp_data, rsp_match, rsp_valid); else passed++;
    checks++; if (sr_in !== IDLE_BIT) $display("[TB] FAIL arst_sr_in got %b expected %b", sr_in, IDLE_BIT); else passed++;
    #3 n_rst = 1'b1;
    @(posedge clk); #1;
    do_txn(4'h6, 0, 1'b0, 1'b0, bits, cap, lat, data, match, stable, va, ra);
    checks++; if (data !== 4'h6 || match !== 1'b1 || bits !== model_serial(4'h6)) $display("[TB] FAIL arst_followup got %h/%b bits %b expected 6/1 bits %b", data, match, bits, model_serial(4'h6)); else passed++;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] bits, cap, data, word, exp_data;
    logic match, va, ra;
    int lat, stall;
    bit stable, fm;
    for (int n = 0; n < 12; n++) begin
      word     = 4'($urandom_range(0, 15));
      stall    = $urandom_range(0, 3);
      fm       = ($urandom_range(0, 3) == 0);
      exp_data = fm ? '0 : word;
      do_txn(word, stall, fm, 1'b0, bits, cap, lat, data, match, stable, va, ra);
      checks++; if (bits !== model_serial(word)) $display("[TB] FAIL rand_serial[%0d] got %b expected %b", n, bits, model_serial(word)); else passed++;
      checks++; if (lat !== WIDTH + 1) $display("[TB] FAIL rand_latency[%0d] got %0d expected %0d", n, lat, WIDTH + 1); else passed++;
      checks++; if (data !== exp_data || match !== (exp_data == word)) $display("[TB] FAIL rand_rsp[%0d] got %h/%b expected %h/%b", n, data, match, exp_data, exp_data == word); else passed++;
      checks++; if (stable !== 1'b1 || va !== 1'b0 || ra !== 1'b1) $display("[TB] FAIL rand_handshake[%0d] got stable=%b valid=%b ready=%b expected 1/0/1", n, stable, va, ra); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_mismatch();
    test_abort();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
